// File: rtl/div_err_pkg.sv
// Shared types, constants and the sample qualification helper for div_err_accumulator.
package div_err_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned DRAIN_CYCLES = 2;
   localparam int unsigned DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int unsigned SKIP_W       = 16;
   localparam int unsigned OPW          = 32;

   // True when the divider result is meaningful: nonzero divisor and the quotient
   // fits in qw bits, i.e. n < d * 2^qw (same as n[hi] < d).
   function automatic logic div_err_qualifies(input logic [OPW-1:0] n,
                                              input logic [OPW-1:0] d,
                                              input int unsigned    qw);
      logic [OPW-1:0] d_sh;
      d_sh = d << qw;
      return (d != '0) && (n < d_sh);
   endfunction

endpackage

// File: rtl/div_err_sq_stage.sv
// Two-stage error path: |a-b| register stage, then square-accumulate with max tracking.
module div_err_sq_stage #(
   parameter int unsigned QW       = 8,
   parameter int unsigned WIN_LOG2 = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         in_valid,
   input  logic [QW-1:0]                a,
   input  logic [QW-1:0]                b,
   output logic [2*QW+WIN_LOG2-1:0]     sum,
   output logic [QW-1:0]                max_err
);

   localparam int unsigned SW = 2*QW + WIN_LOG2;

   logic [QW-1:0]   e_q;
   logic            v_q;
   logic [2*QW-1:0] sq_c;

   assign sq_c = (2*QW)'(e_q) * (2*QW)'(e_q);

   // Stage 1: absolute difference of the two operands for qualified samples.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         e_q <= '0;
         v_q <= 1'b0;
      end else begin
         v_q <= in_valid;
         if (in_valid) begin
            e_q <= (a >= b) ? (a - b) : (b - a);
         end
      end
   end

   // Stage 2: accumulate squared error and keep the running maximum.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sum     <= '0;
         max_err <= '0;
      end else if (v_q) begin
         sum <= sum + SW'(sq_c);
         if (e_q > max_err) begin
            max_err <= e_q;
         end
      end
   end

endmodule

// File: rtl/div_err_accumulator.sv
// Windowed squared-error accumulator for the approximate divider.
// Optional remainder tracking path enabled by DIV_ERR_REM_TRACK_EN.
module div_err_accumulator
   import div_err_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = 8,
   parameter int unsigned QW       = 8,
   parameter int unsigned NW       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NW-1:0]        in_n,
   input  logic [QW-1:0]        in_d,
   input  logic [QW-1:0]        in_q_apx,
   input  logic [QW-1:0]        in_q_ext,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*QW-1:0]      out_mse,
   output logic [QW-1:0]        out_max_err,
   output logic [SKIP_W-1:0]    out_skip
`ifdef DIV_ERR_REM_TRACK_EN
   ,
   input  logic [QW-1:0]        in_r_apx,
   input  logic [QW-1:0]        in_r_ext,
   output logic [2*QW-1:0]      out_rem_mse
`endif
);

   localparam int unsigned SW = 2*QW + WIN_LOG2;

   state_t               state;
   state_t               state_next;
   logic                 clear_c;
   logic                 accept_c;
   logic                 qual_c;
   logic                 acc_qual_c;
   logic                 last_c;
   logic [WIN_LOG2-1:0]  qual_cnt;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic [SKIP_W-1:0]    skip_cnt;
   logic [SW-1:0]        q_sum;
   logic [QW-1:0]        q_max;

   assign accept_c   = in_valid & in_ready;
   assign qual_c     = div_err_qualifies(OPW'(in_n), OPW'(in_d), QW);
   assign acc_qual_c = accept_c & qual_c;
   assign last_c     = &qual_cnt;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and accumulator clear strobe.
   always_comb begin
      state_next = state;
      clear_c    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               clear_c    = 1'b1;
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (acc_qual_c && last_c) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               if (start) begin
                  clear_c    = 1'b1;
                  state_next = ACCUM;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Window, drain and skip counters.
   always_ff @(posedge clk) begin
      if (rst || clear_c) begin
         qual_cnt  <= '0;
         drain_cnt <= '0;
         skip_cnt  <= '0;
      end else begin
         if (acc_qual_c) begin
            qual_cnt <= qual_cnt + WIN_LOG2'(1);
         end
         if (accept_c && !qual_c && (skip_cnt != '1)) begin
            skip_cnt <= skip_cnt + SKIP_W'(1);
         end
         if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
         end else begin
            drain_cnt <= '0;
         end
      end
   end

   // Registered handshake/status outputs; results captured on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         out_valid   <= 1'b0;
         out_mse     <= '0;
         out_max_err <= '0;
         out_skip    <= '0;
      end else begin
         in_ready  <= (state_next == ACCUM);
         busy      <= (state_next == ACCUM) || (state_next == DRAIN);
         out_valid <= (state_next == DONE);
         if ((state == DRAIN) && (state_next == DONE)) begin
            out_mse     <= q_sum[SW-1:WIN_LOG2];
            out_max_err <= q_max;
            out_skip    <= skip_cnt;
         end
      end
   end

   div_err_sq_stage #(
      .QW       (QW),
      .WIN_LOG2 (WIN_LOG2)
   ) u_q_stage (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_c),
      .in_valid (acc_qual_c),
      .a        (in_q_apx),
      .b        (in_q_ext),
      .sum      (q_sum),
      .max_err  (q_max)
   );

`ifdef DIV_ERR_REM_TRACK_EN
   logic [SW-1:0] r_sum;
   logic [QW-1:0] r_max;

   div_err_sq_stage #(
      .QW       (QW),
      .WIN_LOG2 (WIN_LOG2)
   ) u_r_stage (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_c),
      .in_valid (acc_qual_c),
      .a        (in_r_apx),
      .b        (in_r_ext),
      .sum      (r_sum),
      .max_err  (r_max)
   );

   // Remainder MSE captured alongside the quotient results.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_rem_mse <= '0;
      end else if ((state == DRAIN) && (state_next == DONE)) begin
         out_rem_mse <= r_sum[SW-1:WIN_LOG2];
      end
   end
`endif

endmodule

// File: tb/tb_div_err_accumulator.sv
// Scoreboard bench for div_err_accumulator with WIN_LOG2=2.
module tb_div_err_accumulator;

   localparam int unsigned WL = 2;
   localparam int unsigned QW = 8;
   localparam int unsigned NW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NW-1:0] in_n = '0;
   logic [QW-1:0] in_d = '0;
   logic [QW-1:0] in_q_apx = '0;
   logic [QW-1:0] in_q_ext = '0;
   logic          busy;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_mse;
   logic [7:0]    out_max_err;
   logic [15:0]   out_skip;
`ifdef DIV_ERR_REM_TRACK_EN
   logic [QW-1:0] in_r_apx = '0;
   logic [QW-1:0] in_r_ext = '0;
   logic [15:0]   out_rem_mse;
`endif

   typedef struct packed {
      logic [15:0] mse;
      logic [7:0]  mx;
      logic [15:0] skip;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   div_err_accumulator #(.WIN_LOG2(WL), .QW(QW), .NW(NW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_n        (in_n),
      .in_d        (in_d),
      .in_q_apx    (in_q_apx),
      .in_q_ext    (in_q_ext),
      .busy        (busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_mse     (out_mse),
      .out_max_err (out_max_err),
      .out_skip    (out_skip)
`ifdef DIV_ERR_REM_TRACK_EN
      ,
      .in_r_apx    (in_r_apx),
      .in_r_ext    (in_r_ext),
      .out_rem_mse (out_rem_mse)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: compare each result handshake against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (out_valid === 1'b1) && (out_ready === 1'b1)) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("out_mse", 32'(out_mse), 32'(e.mse));
            chk("out_max_err", 32'(out_max_err), 32'(e.mx));
            chk("out_skip", 32'(out_skip), 32'(e.skip));
         end
      end
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic send(input logic [15:0] n, input logic [7:0] d,
                       input logic [7:0] qa, input logic [7:0] qe);
      bit ok;
      int g;
      ok = 1'b0;
      g  = 0;
      in_n = n; in_d = d; in_q_apx = qa; in_q_ext = qe;
      in_valid = 1'b1;
      while (!ok && g < 40) begin
         @(negedge clk);
         ok = (in_ready === 1'b1);
         @(posedge clk);
         #1;
         g++;
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_q(input logic [7:0] qa, input logic [7:0] qe);
      send(16'h0040, 8'h04, qa, qe);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // out_valid must appear in the third cycle after the last accept.
   task automatic check_latency();
      @(negedge clk); chk("lat_c1_valid", 32'(out_valid), 32'd0);
      @(negedge clk); chk("lat_c2_valid", 32'(out_valid), 32'd0);
      @(negedge clk); chk("lat_c3_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic release_result();
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      @(negedge clk);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_mse", 32'(out_mse), 32'd0);
      chk("rst_out_max_err", 32'(out_max_err), 32'd0);
      chk("rst_out_skip", 32'(out_skip), 32'd0);

      // Window 1: zero error.
      @(posedge clk); #1;
      pulse_start();
      for (int i = 0; i < 4; i++) send_q(8'h10, 8'h10);
      sb.push_back('{mse: 16'd0, mx: 8'd0, skip: 16'd0});
      check_latency();
      release_result();

      // Window 2: errors 1..4, sum 30 -> mse 7; then hold in DONE with start pulses.
      @(posedge clk); #1;
      pulse_start();
      send_q(8'h21, 8'h20);
      send_q(8'h22, 8'h20);
      send_q(8'h23, 8'h20);
      send_q(8'h24, 8'h20);
      sb.push_back('{mse: 16'd7, mx: 8'd4, skip: 16'd0});
      check_latency();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         start = (i % 3 == 0);
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_mse", 32'(out_mse), 32'd7);
         chk("hold_max", 32'(out_max_err), 32'd4);
      end
      @(posedge clk); #1;
      start = 1'b0;
      release_result();

      // Window 3: skips (d=0, overflow boundary) interleaved; 04FF/05 still qualifies.
      @(posedge clk); #1;
      pulse_start();
      send(16'h04FF, 8'h05, 8'hF5, 8'hF2);
      send(16'h0040, 8'h00, 8'hFF, 8'h00);
      send_q(8'h10, 8'h10);
      send_q(8'h10, 8'h15);
      send(16'h0500, 8'h05, 8'hFF, 8'h00);
      @(negedge clk);
      chk("w3_in_ready_before_last", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      send_q(8'h11, 8'h10);
      sb.push_back('{mse: 16'd8, mx: 8'd5, skip: 16'd2});
      check_latency();
      release_result();

      // Reset mid-window then a fresh zero-error window.
      @(posedge clk); #1;
      pulse_start();
      send_q(8'h7F, 8'h00);
      send_q(8'h7F, 8'h00);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_mse", 32'(out_mse), 32'd0);
      chk("mid_rst_max", 32'(out_max_err), 32'd0);
      chk("mid_rst_skip", 32'(out_skip), 32'd0);
      @(posedge clk); #1;
      pulse_start();
      for (int i = 0; i < 4; i++) send_q(8'h10, 8'h10);
      sb.push_back('{mse: 16'd0, mx: 8'd0, skip: 16'd0});
      check_latency();
      release_result();

      // Window 5 with one skip; out_ready+start together chain into a clean window.
      @(posedge clk); #1;
      pulse_start();
      send_q(8'h21, 8'h20);
      send(16'h0040, 8'h00, 8'h00, 8'h00);
      send_q(8'h22, 8'h20);
      send_q(8'h23, 8'h20);
      send_q(8'h24, 8'h20);
      sb.push_back('{mse: 16'd7, mx: 8'd4, skip: 16'd1});
      check_latency();
      @(posedge clk); #1;
      out_ready = 1'b1;
      start     = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      start     = 1'b0;
      @(negedge clk);
      chk("chain_busy", 32'(busy), 32'd1);
      chk("chain_in_ready", 32'(in_ready), 32'd1);
      chk("chain_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) send_q(8'h30, 8'h30);
      sb.push_back('{mse: 16'd0, mx: 8'd0, skip: 16'd0});
      check_latency();
      release_result();

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/div_err_accumulator.md
Name: div_err_accumulator

Overview:
- Sits directly downstream of the 8-bit approximate array divider (16-bit dividend, 8-bit divisor).
- Consumes, per sample: the operands, the approximate quotient, and the exact quotient from the reference exact array.
- Accumulates squared quotient error over a window of 2^WIN_LOG2 qualified samples, then reports the MSE, the maximum absolute error and the skipped-sample count through a valid/ready result port.
- Used by the delay-MSE heuristic flow to score approximate cell placements in hardware.

Parameters:
- WIN_LOG2, 8, log2 of the number of qualified samples per window (range 1..16).
- QW, 8, quotient width in bits.
- NW, 16, dividend width in bits (must equal 2*QW).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; opens a new window.
- in_valid  in  1  sample present on the in_* buses.
- in_ready  out  1  block accepts the sample this cycle.
- in_n  in  NW  dividend fed to the divider.
- in_d  in  QW  divisor fed to the divider.
- in_q_apx  in  QW  approximate quotient.
- in_q_ext  in  QW  exact quotient.
- busy  out  1  window in progress (ACCUM or DRAIN).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_mse  out  2*QW  sum of squared errors >> WIN_LOG2 (truncating).
- out_max_err  out  QW  maximum |q_apx - q_ext| over the window.
- out_skip  out  16  count of disqualified samples, saturating at 16'hFFFF.

Behaviour:
- Reset (synchronous, active-high): state IDLE. in_ready=0, busy=0, out_valid=0. out_mse, out_max_err and out_skip are all 0. All accumulators and counters are cleared. rst asserted mid-window abandons the window with no result.
- State machine IDLE -> ACCUM -> DRAIN -> DONE:
  - IDLE: on start, clear the accumulators and go to ACCUM.
  - ACCUM: in_ready=1. A sample is accepted when in_valid & in_ready.
  - ACCUM -> DRAIN: on the cycle the 2^WIN_LOG2-th qualified sample is accepted. in_ready drops the next cycle.
  - DRAIN: fixed 2 cycles to flush the pipeline, then DONE.
  - DONE: out_valid=1 and outputs held stable until out_ready. On out_ready, go to IDLE. If start is also high in that same cycle, go directly to ACCUM with cleared accumulators.
- start is ignored in ACCUM and DRAIN, and in DONE without out_ready.
- Qualification: a sample is skipped if in_d==0 or in_n[NW-1:QW] >= in_d (quotient overflow). A skipped sample is accepted, increments the skip counter (saturating), and does not count toward the window.
- Pipeline, 2 stages:
  - S1 registers e = |q_apx - q_ext| (QW bits, unsigned) plus a qualified flag.
  - S2 computes e*e (2*QW bits), adds it to sum (2*QW+WIN_LOG2 bits, never overflows), and updates max_err.
  - Latency from the last accept to out_valid is 3 cycles.
- Output computation: out_mse = sum[2*QW+WIN_LOG2-1:WIN_LOG2].
- A window never completes on skipped samples alone. The block stays in ACCUM indefinitely until enough qualified samples arrive.
- in_valid with in_ready=0 has no effect; upstream holds the sample.

Optional Feature:
- Macro DIV_ERR_REM_TRACK_EN.
- Defined: adds inputs in_r_apx and in_r_ext (QW bits each) and output out_rem_mse (2*QW bits). The remainder squared error is accumulated in a parallel path with identical latency and skip rules.
- Undefined: those ports and that logic are absent. The quotient-only behaviour is unchanged.

Decomposition:
- Package div_err_pkg holds:
  - state enum {IDLE, ACCUM, DRAIN, DONE};
  - DRAIN_CYCLES = 2;
  - SKIP_W = 16;
  - a function for the overflow/zero-divisor qualification.
- One sub-module, div_err_sq_stage: abs-difference register stage plus square-accumulate stage with max tracking. It is instantiated twice when DIV_ERR_REM_TRACK_EN is defined.

Test Plan:
- WIN_LOG2=2; start; 4 samples with q_apx=q_ext=0x10, n=0x0040, d=0x04 -> out_valid 3 cycles after the 4th accept; out_mse=0, out_max_err=0, out_skip=0.
- WIN_LOG2=2; errors 1,2,3,4 (q_ext=0x20, q_apx=0x21/0x22/0x23/0x24) -> sum=30, out_mse=7, out_max_err=4.
- Interleave d=0 and n=0x0500/d=0x05 samples with 4 qualified samples -> those 2 samples skipped, out_skip=2, window still closes after 4 qualified samples.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and outputs stable; in_ready=0; start pulses ignored.
- Assert rst for 1 cycle after 2 accepted samples -> IDLE, all outputs 0; a fresh start with 4 zero-error samples gives out_mse=0 (no stale sum).
- out_ready and start in the same DONE cycle -> next cycle busy=1, in_ready=1, accumulators cleared.
